// File: rtl/matmul4x4_tile_sched_if.sv
// matmul4x4_tile_sched_if: command/result handshake plus 2x2 multiplier pins of the tile scheduler.
interface matmul4x4_tile_sched_if #(
    parameter int DW = 8,
    parameter int CW = 2*DW+2
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [16*DW-1:0]  a_in;
    logic [16*DW-1:0]  b_in;
    logic              res_valid;
    logic              res_ready;
    logic [16*CW-1:0]  c_out;
    logic              busy;
    logic              mm_start;
    logic [DW-1:0]     mm_a00, mm_a01, mm_a10, mm_a11;
    logic [DW-1:0]     mm_b00, mm_b01, mm_b10, mm_b11;
    logic [2*DW:0]     mm_c00, mm_c01, mm_c10, mm_c11;
    logic              mm_done;

    modport master (
        output cmd_valid, a_in, b_in, res_ready, mm_c00, mm_c01, mm_c10, mm_c11, mm_done,
        input  cmd_ready, res_valid, c_out, busy, mm_start,
               mm_a00, mm_a01, mm_a10, mm_a11, mm_b00, mm_b01, mm_b10, mm_b11
    );
    modport slave (
        input  cmd_valid, a_in, b_in, res_ready, mm_c00, mm_c01, mm_c10, mm_c11, mm_done,
        output cmd_ready, res_valid, c_out, busy, mm_start,
               mm_a00, mm_a01, mm_a10, mm_a11, mm_b00, mm_b01, mm_b10, mm_b11
    );
endinterface

// File: rtl/matmul4x4_tile_sched.sv
// matmul4x4_tile_sched: computes C = A*B (4x4) as eight 2x2 block products on one shared
// multiplier, accumulating each 2x2 tile of C over the inner index k.
module matmul4x4_tile_sched #(
    parameter int DW = 8,
    parameter int CW = 2*DW+2
) (
    input logic clk,
    input logic rst,
    matmul4x4_tile_sched_if.slave bus
);
    localparam int MW = 2*DW+1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t            state_q, state_d;
    logic [2:0]        s_q, s_d;
    logic [16*DW-1:0]  a_q, a_d, b_q, b_d;
    logic [4*DW-1:0]   ma_q, ma_d, mb_q, mb_d;
    logic [16*CW-1:0]  acc_q, acc_d;
    logic [4*MW-1:0]   mc;
    logic              load;

    assign mc = {bus.mm_c11, bus.mm_c10, bus.mm_c01, bus.mm_c00};

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        a_d     = a_q;
        b_d     = b_q;
        ma_d    = ma_q;
        mb_d    = mb_q;
        acc_d   = acc_q;
        load    = 1'b0;
        unique case (state_q)
            IDLE: if (bus.cmd_valid) begin
                state_d = ISSUE;
                a_d     = bus.a_in;
                b_d     = bus.b_in;
                s_d     = '0;
                acc_d   = '0;
                load    = 1'b1;
            end
            ISSUE: state_d = WAIT;
            WAIT: if (bus.mm_done) begin
                // k=0 loads the tile, k=1 adds the second partial product
                for (int x = 0; x < 2; x++)
                    for (int y = 0; y < 2; y++)
                        acc_d[CW*(4*(2*s_q[2]+x)+2*s_q[1]+y) +: CW] = s_q[0]
                            ? acc_q[CW*(4*(2*s_q[2]+x)+2*s_q[1]+y) +: CW] + CW'(mc[MW*(2*x+y) +: MW])
                            : CW'(mc[MW*(2*x+y) +: MW]);
                state_d = (s_q == 3'd7) ? DONE : ISSUE;
                s_d     = (s_q == 3'd7) ? s_q : s_q + 3'd1;
                load    = (s_q != 3'd7);
            end
            DONE: if (bus.res_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // operands for the step about to be issued, held until the next issue
        if (load)
            for (int x = 0; x < 2; x++)
                for (int y = 0; y < 2; y++) begin
                    ma_d[DW*(2*x+y) +: DW] = a_d[DW*(4*(2*s_d[2]+x)+2*s_d[0]+y) +: DW];
                    mb_d[DW*(2*x+y) +: DW] = b_d[DW*(4*(2*s_d[0]+x)+2*s_d[1]+y) +: DW];
                end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            s_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            ma_q    <= '0;
            mb_q    <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            a_q     <= a_d;
            b_q     <= b_d;
            ma_q    <= ma_d;
            mb_q    <= mb_d;
            acc_q   <= acc_d;
        end
    end

    assign bus.cmd_ready = (state_q == IDLE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.res_valid = (state_q == DONE);
    assign bus.mm_start  = (state_q == ISSUE);
    assign bus.c_out     = acc_q;
    assign bus.mm_a00    = ma_q[0*DW +: DW];
    assign bus.mm_a01    = ma_q[1*DW +: DW];
    assign bus.mm_a10    = ma_q[2*DW +: DW];
    assign bus.mm_a11    = ma_q[3*DW +: DW];
    assign bus.mm_b00    = mb_q[0*DW +: DW];
    assign bus.mm_b01    = mb_q[1*DW +: DW];
    assign bus.mm_b10    = mb_q[2*DW +: DW];
    assign bus.mm_b11    = mb_q[3*DW +: DW];
endmodule

// File: tb/tb_matmul4x4_tile_sched.sv
// tb_matmul4x4_tile_sched: directed and random checks of the 4x4 tile scheduler against a
// behavioural 2x2 multiplier with programmable done latency.
module tb_matmul4x4_tile_sched;
    logic clk = 1'b0;
    logic rst;
    int vec = 0;
    int errs = 0;
    int mm_delay = 1;
    int mm_cnt = 0;
    int starts = 0;
    int wide_err = 0;
    int stab_err = 0;
    logic prev_start = 1'b0;
    logic [63:0] snap = '0;
    logic [63:0] ops;

    always #5 clk = ~clk;

    matmul4x4_tile_sched_if #(.DW(8)) bus ();

    matmul4x4_tile_sched #(.DW(8)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [16:0] dp(input logic [7:0] a0, b0, a1, b1);
        return 17'(a0) * 17'(b0) + 17'(a1) * 17'(b1);
    endfunction

    // Behavioural 2x2 multiplier: done arrives mm_delay cycles after start
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mm_cnt <= 0;
            bus.mm_done <= 1'b0;
            bus.mm_c00 <= '0; bus.mm_c01 <= '0; bus.mm_c10 <= '0; bus.mm_c11 <= '0;
        end else begin
            bus.mm_done <= 1'b0;
            if ((bus.mm_start && mm_delay == 1) || (!bus.mm_start && mm_cnt == 1)) begin
                bus.mm_done <= 1'b1;
                bus.mm_c00 <= dp(bus.mm_a00, bus.mm_b00, bus.mm_a01, bus.mm_b10);
                bus.mm_c01 <= dp(bus.mm_a00, bus.mm_b01, bus.mm_a01, bus.mm_b11);
                bus.mm_c10 <= dp(bus.mm_a10, bus.mm_b00, bus.mm_a11, bus.mm_b10);
                bus.mm_c11 <= dp(bus.mm_a10, bus.mm_b01, bus.mm_a11, bus.mm_b11);
            end
            if (bus.mm_start) mm_cnt <= mm_delay - 1;
            else if (mm_cnt > 0) mm_cnt <= mm_cnt - 1;
        end
    end

    always @(posedge clk) begin
        if (!rst && bus.mm_start) begin
            starts++;
            if (prev_start) wide_err++;
        end
        prev_start = bus.mm_start;
    end

    assign ops = {bus.mm_a00, bus.mm_a01, bus.mm_a10, bus.mm_a11,
                  bus.mm_b00, bus.mm_b01, bus.mm_b10, bus.mm_b11};

    // Operands must not move while a step is waiting for the multiplier
    always @(negedge clk) begin
        if (bus.mm_start) snap = ops;
        else if (bus.busy && !bus.res_valid && ops !== snap) stab_err++;
    end

    function automatic logic [16*18-1:0] ref_mm(input logic [127:0] a, input logic [127:0] b);
        logic [16*18-1:0] c;
        logic [17:0] sum;
        for (int r = 0; r < 4; r++)
            for (int q = 0; q < 4; q++) begin
                sum = '0;
                for (int k = 0; k < 4; k++)
                    sum += 18'(a[8*(4*r+k) +: 8]) * 18'(b[8*(4*k+q) +: 8]);
                c[18*(4*r+q) +: 18] = sum;
            end
        return c;
    endfunction

    function automatic logic [127:0] ident();
        logic [127:0] m;
        for (int i = 0; i < 16; i++) m[8*i +: 8] = (i % 5 == 0) ? 8'd1 : 8'd0;
        return m;
    endfunction

    function automatic logic [127:0] seq_b();
        logic [127:0] m;
        for (int i = 0; i < 16; i++) m[8*i +: 8] = 8'(i + 1);
        return m;
    endfunction

    function automatic logic [127:0] rnd_m();
        logic [127:0] m;
        for (int i = 0; i < 4; i++) m[32*i +: 32] = $urandom;
        return m;
    endfunction

    task automatic run_cmd(input logic [127:0] a, input logic [127:0] b, output int lat);
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.a_in = a;
        bus.b_in = b;
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        lat = 1;
        while (!bus.res_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        if (!bus.res_valid) lat = -1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        vec++;
        if ({bus.cmd_ready, bus.res_valid, bus.busy, bus.mm_start} !== 4'b1000) begin
            errs++;
            $display("FAIL reset_ctrl: got %b expected 1000", {bus.cmd_ready, bus.res_valid, bus.busy, bus.mm_start});
        end
        vec++;
        if (bus.c_out !== '0 || ops !== '0) begin
            errs++;
            $display("FAIL reset_data: c_out %h ops %h expected zero", bus.c_out, ops);
        end
        rst = 1'b0;
        @(negedge clk);
        vec++;
        if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0) begin
            errs++;
            $display("FAIL reset_release: cmd_ready %b busy %b expected 1 0", bus.cmd_ready, bus.busy);
        end
    endtask

    task automatic test_identity();
        int lat;
        int s0;
        int w0;
        logic [16*18-1:0] exp_c;
        for (int i = 0; i < 16; i++) exp_c[18*i +: 18] = 18'(i + 1);
        s0 = starts;
        w0 = wide_err;
        run_cmd(ident(), seq_b(), lat);
        vec++;
        if (lat !== 17) begin
            errs++;
            $display("FAIL ident_latency: got %0d expected 17", lat);
        end
        vec++;
        if (bus.c_out !== exp_c) begin
            errs++;
            $display("FAIL ident_result: got %h expected %h", bus.c_out, exp_c);
        end
        vec++;
        if (starts - s0 !== 8 || wide_err !== w0) begin
            errs++;
            $display("FAIL ident_start_pulses: got %0d pulses %0d wide expected 8 0", starts - s0, wide_err - w0);
        end
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
        vec++;
        if (bus.cmd_ready !== 1'b1 || bus.res_valid !== 1'b0) begin
            errs++;
            $display("FAIL ident_handshake: cmd_ready %b res_valid %b expected 1 0", bus.cmd_ready, bus.res_valid);
        end
    endtask

    task automatic test_max();
        int lat;
        logic [127:0] ff;
        logic [16*18-1:0] exp_c;
        ff = '1;
        for (int i = 0; i < 16; i++) exp_c[18*i +: 18] = 18'h3F804;
        run_cmd(ff, ff, lat);
        vec++;
        if (bus.c_out !== exp_c) begin
            errs++;
            $display("FAIL max_result: got %h expected %h", bus.c_out, exp_c);
        end
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
    endtask

    task automatic test_random();
        int lat;
        logic [127:0] a;
        logic [127:0] b;
        bus.res_ready = 1'b1;
        for (int n = 0; n < 200; n++) begin
            a = rnd_m();
            b = rnd_m();
            run_cmd(a, b, lat);
            vec++;
            if (bus.c_out !== ref_mm(a, b) || lat !== 17) begin
                errs++;
                $display("FAIL random_%0d: got %h lat %0d expected %h lat 17", n, bus.c_out, lat, ref_mm(a, b));
            end
            @(negedge clk);
            vec++;
            if (bus.cmd_ready !== 1'b1) begin
                errs++;
                $display("FAIL random_ready_%0d: cmd_ready %b expected 1", n, bus.cmd_ready);
            end
        end
        bus.res_ready = 1'b0;
    endtask

    task automatic test_back_pressure();
        int lat;
        logic [127:0] a;
        logic [127:0] b;
        logic [16*18-1:0] hold;
        a = rnd_m();
        b = rnd_m();
        run_cmd(a, b, lat);
        hold = bus.c_out;
        vec++;
        if (hold !== ref_mm(a, b)) begin
            errs++;
            $display("FAIL bp_result: got %h expected %h", hold, ref_mm(a, b));
        end
        for (int i = 0; i < 10; i++) begin
            bus.cmd_valid = i[0];
            bus.a_in = ~a;
            bus.b_in = ~b;
            @(negedge clk);
            vec++;
            if (bus.res_valid !== 1'b1 || bus.cmd_ready !== 1'b0 || bus.c_out !== hold) begin
                errs++;
                $display("FAIL bp_hold_%0d: res_valid %b cmd_ready %b c_out %h expected 1 0 %h",
                         i, bus.res_valid, bus.cmd_ready, bus.c_out, hold);
            end
        end
        bus.cmd_valid = 1'b0;
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
        vec++;
        if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0) begin
            errs++;
            $display("FAIL bp_release: cmd_ready %b busy %b expected 1 0", bus.cmd_ready, bus.busy);
        end
    endtask

    task automatic test_slow_mult();
        int lat;
        int e0;
        logic [127:0] a;
        logic [127:0] b;
        a = rnd_m();
        b = rnd_m();
        mm_delay = 3;
        e0 = stab_err;
        run_cmd(a, b, lat);
        vec++;
        if (lat !== 33 || bus.c_out !== ref_mm(a, b)) begin
            errs++;
            $display("FAIL slow_result: got %h lat %0d expected %h lat 33", bus.c_out, lat, ref_mm(a, b));
        end
        vec++;
        if (stab_err !== e0) begin
            errs++;
            $display("FAIL slow_operand_hold: got %0d changes expected 0", stab_err - e0);
        end
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
        mm_delay = 1;
    endtask

    task automatic test_reset_mid();
        int lat;
        logic [16*18-1:0] exp_c;
        for (int i = 0; i < 16; i++) exp_c[18*i +: 18] = 18'(i + 1);
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.a_in = ident();
        bus.b_in = seq_b();
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        #1;
        vec++;
        if ({bus.cmd_ready, bus.res_valid, bus.busy, bus.mm_start} !== 4'b1000 || bus.c_out !== '0 || ops !== '0) begin
            errs++;
            $display("FAIL midreset_outputs: ctrl %b c_out %h ops %h expected 1000 0 0",
                     {bus.cmd_ready, bus.res_valid, bus.busy, bus.mm_start}, bus.c_out, ops);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        vec++;
        if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0) begin
            errs++;
            $display("FAIL midreset_ready: cmd_ready %b busy %b expected 1 0", bus.cmd_ready, bus.busy);
        end
        run_cmd(ident(), seq_b(), lat);
        vec++;
        if (lat !== 17 || bus.c_out !== exp_c) begin
            errs++;
            $display("FAIL midreset_rerun: got %h lat %0d expected %h lat 17", bus.c_out, lat, exp_c);
        end
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.a_in = '0;
        bus.b_in = '0;
        bus.res_ready = 1'b0;
        test_reset();
        test_identity();
        test_max();
        test_random();
        test_back_pressure();
        test_slow_mult();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
